// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: coin FSM states, joystick bit indices and 4-way direction priority
package input_conditioner_pkg;
   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
   localparam int DIR_RIGHT = 0;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_UP    = 3;
   localparam int COIN_BIT  = 7;
   function automatic logic [3:0] dir_pri(input logic [3:0] d);
      return d[DIR_UP]    ? 4'b1 << DIR_UP :
             d[DIR_DOWN]  ? 4'b1 << DIR_DOWN :
             d[DIR_LEFT]  ? 4'b1 << DIR_LEFT :
             d[DIR_RIGHT] ? 4'b1 << DIR_RIGHT : 4'b0000;
   endfunction
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: three-sample agreement filter (two stored samples plus the incoming one) advanced on tick
module debounce_bit (
   input  logic clk_sys,
   input  logic reset,
   input  logic tick,
   input  logic sample,
   output logic db
);
   logic [1:0] hist;
   always_ff @(posedge clk_sys)
      if (reset) begin
         hist <= '0;
         db   <= 1'b0;
      end else if (tick) begin
         hist <= {hist[0], sample};
         db   <= hist == {2{sample}} ? sample : db;
      end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced joystick word, newest-wins 4-way direction and shaped, queued coin pulses
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int COIN_PULSE_CYCLES = 2500000,
   parameter int COIN_GAP_CYCLES   = 2500000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] joy_in,
   output logic [15:0] joy_db,
   output logic [3:0]  dir4,
   output logic        coin_out,
   output logic        coin_busy
);
   localparam int PW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CMAX = COIN_PULSE_CYCLES > COIN_GAP_CYCLES ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
   localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;

   logic [PW-1:0] pre;
   logic          tick;
   logic [3:0]    dir_prev, pressed, dir_next;
   logic          coin_prev, coin_edge, take;
   logic [1:0]    pending, pend_next;
   coin_state_t   state, state_next;
   logic [CW-1:0] cnt, cnt_next;

   assign tick = pre == PW'(DEBOUNCE_CYCLES - 1);

   for (genvar b = 0; b < 16; b++) begin : g_db
      debounce_bit u_debounce_bit (
         .clk_sys (clk_sys),
         .reset   (reset),
         .tick    (tick),
         .sample  (joy_in[b]),
         .db      (joy_db[b])
      );
   end

   // a fresh press takes over; otherwise keep the held direction until it is released
   always_comb begin
      pressed  = joy_db[3:0] & ~dir_prev;
      dir_next = |pressed ? dir_pri(pressed) :
                 |(dir4 & joy_db[3:0]) ? dir4 : dir_pri(joy_db[3:0]);
   end

   assign coin_edge = joy_db[COIN_BIT] & ~coin_prev;

   always_comb begin
      state_next = state;
      cnt_next   = cnt + CW'(1);
      take       = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (pending != 2'd0) begin
               state_next = PULSE;
               take       = 1'b1;
            end
         end
         PULSE: if (cnt == CW'(COIN_PULSE_CYCLES - 1)) begin
            state_next = GAP;
            cnt_next   = '0;
         end
         GAP: if (cnt == CW'(COIN_GAP_CYCLES - 1)) begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: state_next = IDLE;
      endcase
      pend_next = coin_edge && !take ? (pending == 2'd3 ? pending : pending + 2'd1) :
                  take && !coin_edge ? pending - 2'd1 : pending;
   end

   always_ff @(posedge clk_sys)
      if (reset) begin
         pre       <= '0;
         dir_prev  <= '0;
         dir4      <= '0;
         coin_prev <= 1'b0;
         pending   <= '0;
         state     <= IDLE;
         cnt       <= '0;
      end else begin
         pre       <= tick ? '0 : pre + PW'(1);
         dir_prev  <= joy_db[3:0];
         dir4      <= dir_next;
         coin_prev <= joy_db[COIN_BIT];
         pending   <= pend_next;
         state     <= state_next;
         cnt       <= cnt_next;
      end

   assign coin_out  = state == PULSE;
   assign coin_busy = state != IDLE || pending != 2'd0;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce latency, 4-way mapping and coin pulse shaping
module tb_input_conditioner;
   logic        clk_sys = 1'b0;
   logic        reset_a, reset_b;
   logic [15:0] joy_a, joy_b, db_a, db_b;
   logic [3:0]  dir_a, dir_b;
   logic        coin_a, busy_a, coin_b, busy_b;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk_sys = ~clk_sys;

   input_conditioner #(.DEBOUNCE_CYCLES(4), .COIN_PULSE_CYCLES(8), .COIN_GAP_CYCLES(4)) u_a (
      .clk_sys   (clk_sys),
      .reset     (reset_a),
      .joy_in    (joy_a),
      .joy_db    (db_a),
      .dir4      (dir_a),
      .coin_out  (coin_a),
      .coin_busy (busy_a)
   );

   // long pulse and fast debounce so several coin edges fit inside one pulse
   input_conditioner #(.DEBOUNCE_CYCLES(1), .COIN_PULSE_CYCLES(64), .COIN_GAP_CYCLES(4)) u_b (
      .clk_sys   (clk_sys),
      .reset     (reset_b),
      .joy_in    (joy_b),
      .joy_db    (db_b),
      .dir4      (dir_b),
      .coin_out  (coin_b),
      .coin_busy (busy_b)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   initial begin
      int   t, hi, lo;
      logic busy_ok, seen;
      reset_a = 1'b1;
      reset_b = 1'b1;
      joy_a   = 16'hffff;
      joy_b   = 16'h0000;
      step(3);
      check("rst_db", db_a, 0);
      check("rst_dir", dir_a, 0);
      check("rst_coin", coin_a, 0);
      check("rst_busy", busy_a, 0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      joy_a   = 16'h0000;
      step(3);
      joy_a = 16'h0003;
      step(3);
      joy_a = 16'h0001;
      step(5);
      check("db0_8", db_a, 16'h0000);
      step(1);
      check("db0_9", db_a, 16'h0001);
      check("dir_lag", dir_a, 0);
      step(1);
      check("dir_right", dir_a, 4'b0001);
      step(12);
      check("glitch", db_a, 16'h0001);
      joy_a = 16'h0009; step(16); check("up_wins", dir_a, 4'b1000);
      joy_a = 16'h0001; step(16); check("back_right", dir_a, 4'b0001);
      joy_a = 16'h0000; step(16); check("none", dir_a, 4'b0000);
      joy_a = 16'h000e; step(16); check("pri_up", dir_a, 4'b1000);
      joy_a = 16'h0006; step(16); check("fall_down", dir_a, 4'b0100);
      joy_a = 16'h0007; step(16); check("new_right", dir_a, 4'b0001);
      joy_a = 16'h0000; step(16);
      joy_a = 16'h0080;
      t = 0;
      while (!coin_a && t < 40) begin t++; step(1); end
      check("a_rise", coin_a, 1);
      check("db_coin", db_a, 16'h0080);
      hi = 0;
      busy_ok = 1'b1;
      while (coin_a && hi < 100) begin busy_ok &= busy_a; hi++; step(1); end
      check("a_pulse", hi, 8);
      lo = 0;
      while (!coin_a && busy_a && lo < 100) begin lo++; step(1); end
      check("a_gap", lo, 4);
      check("a_busy", busy_ok, 1);
      check("a_idle", busy_a, 0);
      seen = 1'b0;
      repeat (20) begin seen |= coin_a; step(1); end
      check("a_once", seen, 0);
      reset_a = 1'b1;
      joy_a   = 16'h0001;
      step(2);
      check("rst_hold_db", db_a, 0);
      check("rst_hold_dir", dir_a, 0);
      reset_a = 1'b0;
      t = 0;
      while (!db_a[0] && t < 30) begin t++; step(1); end
      check("rst_lat", t, 12);
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               joy_b[7] = 1'b1; step(4);
               joy_b[7] = 1'b0; step(4);
            end
         end
         begin
            int   tw, hb, lb;
            logic sb;
            tw = 0;
            while (!coin_b && tw < 40) begin tw++; step(1); end
            check("b_rise", coin_b, 1);
            for (int p = 0; p < 4; p++) begin
               hb = 0;
               while (coin_b && hb < 200) begin hb++; step(1); end
               check("b_pulse", hb, 64);
               lb = 0;
               while (!coin_b && busy_b && lb < 50) begin lb++; step(1); end
               if (p < 3) begin
                  check("b_next", coin_b, 1);
                  check("b_gap_ok", lb >= 4 && lb <= 5, 1);
               end else begin
                  check("b_last_gap", lb, 4);
                  check("b_idle", busy_b, 0);
               end
            end
            sb = 1'b0;
            repeat (100) begin sb |= coin_b; step(1); end
            check("b_sat", sb, 0);
         end
      join
      for (int k = 0; k < 4; k++) begin
         joy_b[7] = 1'b1; step(4);
         joy_b[7] = 1'b0; step(4);
      end
      t = 0;
      while (coin_b && t < 200) begin t++; step(1); end
      while (!coin_b && t < 200) begin t++; step(1); end
      check("b2_rise", coin_b, 1);
      step(2);
      reset_b = 1'b1;
      step(1);
      check("b2_drop", coin_b, 0);
      check("b2_busy", busy_b, 0);
      reset_b = 1'b0;
      seen = 1'b0;
      repeat (150) begin seen |= coin_b | busy_b; step(1); end
      check("b2_flush", seen, 0);
      joy_b[7] = 1'b1;
      step(4);
      joy_b[7] = 1'b0;
      t = 0;
      while (!coin_b && t < 20) begin t++; step(1); end
      check("b2_new", coin_b, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
